// File: rtl/apb_arbiter2.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing, pulse completion.
// Optional ACCESS timeout is compiled in with APBARB_TIMEOUT_EN.
module apb_arbiter2 #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [1:0]                 ReqValid,
  input  logic [1:0][ADDR_W-1:0]     ReqAddr,
  input  logic [1:0]                 ReqWrite,
  input  logic [1:0][XLEN-1:0]       ReqWData,
  input  logic [1:0][XLEN/8-1:0]     ReqStrb,
  output logic [1:0]                 ReqReady,
  output logic [XLEN-1:0]            ReqRData,
  output logic                       ReqErr,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [XLEN-1:0]            PWDATA,
  output logic [XLEN/8-1:0]          PSTRB,
  input  logic [XLEN-1:0]            PRDATA,
  input  logic                       PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   pick;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_arbiter2: TIMEOUT_CYCLES must be at least 1");
  end

  // Tie goes to the requester that was not served last.
  always_comb begin
    pick = 1'b0;
    if (&ReqValid)
      pick = ~last_grant;
    else if (ReqValid[1])
      pick = 1'b1;
  end

`ifdef APBARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Abort on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      wait_cnt <= '0;
    else if (state == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !PREADY && !timeout_hit)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      ReqReady   <= '0;
      ReqRData   <= '0;
      ReqErr     <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|ReqValid) begin
            grant  <= pick;
            PADDR  <= ReqAddr[pick];
            PWRITE <= ReqWrite[pick];
            PWDATA <= ReqWData[pick];
            PSTRB  <= ReqStrb[pick];
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            PSEL            <= 1'b0;
            PENABLE         <= 1'b0;
            ReqReady[grant] <= 1'b1;
            ReqRData        <= (timeout_hit || PWRITE) ? '0 : PRDATA;
            ReqErr          <= timeout_hit;
            state           <= RESP;
          end
        end
        RESP: begin
          ReqReady   <= '0;
          ReqRData   <= '0;
          ReqErr     <= 1'b0;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
